// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// One operation in flight; MUL takes MUL_LAT EXEC cycles, everything else one.
module alu_share_arbiter #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_data1_i,
    input  logic [31:0] req0_data2_i,
    input  logic [2:0]  req0_ctrl_i,
    output logic        rsp0_valid_o,
    input  logic        rsp0_ready_i,
    output logic [31:0] rsp0_data_o,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_data1_i,
    input  logic [31:0] req1_data2_i,
    input  logic [2:0]  req1_ctrl_i,
    output logic        rsp1_valid_o,
    input  logic        rsp1_ready_i,
    output logic [31:0] rsp1_data_o,
    output logic        busy_o,
    output logic        owner_o
);

    // Handshake rule on all four channels: a transfer happens at the rising
    // edge where valid && ready are both high; ready is only offered in IDLE
    // for requests and only the owner's response carries valid in RESP.

    // ALUCtrl encodings; codes 3'b101..3'b111 are undefined and yield 0.
    localparam logic [2:0] CTRL_ADD = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_AND = 3'b010;
    localparam logic [2:0] CTRL_SUB = 3'b011;
    localparam logic [2:0] CTRL_MUL = 3'b100;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [2:0]  ctrl;
    logic        owner;
    logic        last_grant;
    logic [3:0]  cnt;
    logic [31:0] result;

    logic        grant;
    logic        grant_valid;
    logic        accept;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [2:0]  sel_ctrl;
    logic [31:0] alu_out;
    logic        rsp_fire;

    // Both requesting: alternate away from the previous winner.
    always_comb begin
        grant       = 1'b0;
        grant_valid = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant       = ~last_grant;
            grant_valid = 1'b1;
        end else if (req0_valid_i) begin
            grant       = 1'b0;
            grant_valid = 1'b1;
        end else if (req1_valid_i) begin
            grant       = 1'b1;
            grant_valid = 1'b1;
        end
    end

    assign accept   = (state == IDLE) && grant_valid;
    assign sel_a    = grant ? req1_data1_i : req0_data1_i;
    assign sel_b    = grant ? req1_data2_i : req0_data2_i;
    assign sel_ctrl = grant ? req1_ctrl_i  : req0_ctrl_i;
    assign rsp_fire = (state == RESP) && (owner ? rsp1_ready_i : rsp0_ready_i);

    always_comb begin
        alu_out = 32'd0;
        case (ctrl)
            CTRL_ADD: alu_out = opa + opb;
            CTRL_OR:  alu_out = opa | opb;
            CTRL_AND: alu_out = opa & opb;
            CTRL_SUB: alu_out = opa - opb;
            CTRL_MUL: alu_out = opa * opb;
            default:  alu_out = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;
        rsp0_data_o  = 32'd0;
        rsp1_data_o  = 32'd0;
        case (state)
            IDLE: begin
                req0_ready_o = grant_valid && !grant;
                req1_ready_o = grant_valid && grant;
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (owner) begin
                    rsp1_valid_o = 1'b1;
                    rsp1_data_o  = result;
                end else begin
                    rsp0_valid_o = 1'b1;
                    rsp0_data_o  = result;
                end
                // Retiring goes to IDLE, so no request can be taken this cycle.
                if (rsp_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            opa        <= 32'd0;
            opb        <= 32'd0;
            ctrl       <= 3'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            result     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opa        <= sel_a;
                        opb        <= sel_b;
                        ctrl       <= sel_ctrl;
                        owner      <= grant;
                        last_grant <= grant;
                        cnt        <= (sel_ctrl == CTRL_MUL) ? MUL_CNT : 4'd0;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        result <= alu_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o  = (state != IDLE);
    assign owner_o = owner;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: reset, latency, arbitration,
// backpressure, arithmetic edges, mid-operation reset and fairness.
module tb_alu_share_arbiter;

    localparam int MUL_LAT = 3;
    localparam logic [2:0] C_ADD = 3'b000;
    localparam logic [2:0] C_OR  = 3'b001;
    localparam logic [2:0] C_AND = 3'b010;
    localparam logic [2:0] C_SUB = 3'b011;
    localparam logic [2:0] C_MUL = 3'b100;
    localparam logic [2:0] C_BAD = 3'b111;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_data1;
    logic [31:0] req0_data2;
    logic [2:0]  req0_ctrl;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_data1;
    logic [31:0] req1_data2;
    logic [2:0]  req1_ctrl;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_data;
    logic        busy;
    logic        owner;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];

    alu_share_arbiter #(.MUL_LAT(MUL_LAT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_data1_i (req0_data1),
        .req0_data2_i (req0_data2),
        .req0_ctrl_i  (req0_ctrl),
        .rsp0_valid_o (rsp0_valid),
        .rsp0_ready_i (rsp0_ready),
        .rsp0_data_o  (rsp0_data),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_data1_i (req1_data1),
        .req1_data2_i (req1_data2),
        .req1_ctrl_i  (req1_ctrl),
        .rsp1_valid_o (rsp1_valid),
        .rsp1_ready_i (rsp1_ready),
        .rsp1_data_o  (rsp1_data),
        .busy_o       (busy),
        .owner_o      (owner)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data1 = 32'd0;
        req0_data2 = 32'd0;
        req0_ctrl  = 3'd0;
        req1_data1 = 32'd0;
        req1_data2 = 32'd0;
        req1_ctrl  = 3'd0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic drive_req(input int port, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic [2:0] c);
        if (port == 0) begin
            req0_valid = v; req0_data1 = a; req0_data2 = b; req0_ctrl = c;
        end else begin
            req1_valid = v; req1_data1 = a; req1_data2 = b; req1_ctrl = c;
        end
    endtask

    // One full transaction on one port; lat = cycles from acceptance edge to rsp valid.
    task automatic run_op(input int port, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] c, output logic [31:0] data, output int lat);
        int n;
        data = 32'd0;
        lat  = -1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive_req(port, 1'b1, a, b, c);
        #1;
        n = 0;
        while (((port == 0) ? req0_ready : req1_ready) !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL run_op_accept_timeout port=%0d", port);
            drive_req(port, 1'b0, 32'd0, 32'd0, 3'd0);
            return;
        end
        tick();
        drive_req(port, 1'b0, 32'd0, 32'd0, 3'd0);
        n = 1;
        while (((port == 0) ? rsp0_valid : rsp1_valid) !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) begin
            checks++;
            errors++;
            $display("FAIL run_op_rsp_timeout port=%0d", port);
            return;
        end
        data = (port == 0) ? rsp0_data : rsp1_data;
        lat  = n;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, owner, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {busy, owner, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
        checks++;
        if (rsp0_data !== 32'd0 || rsp1_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got=%h/%h exp=0/0", rsp0_data, rsp1_data);
        end
    endtask

    task automatic test_single_add();
        rsp0_ready = 1'b1;
        drive_req(0, 1'b1, 32'd5, 32'd7, C_ADD);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL add_accept got r0=%b r1=%b busy=%b exp 1 0 0", req0_ready, req1_ready, busy);
        end
        tick();
        drive_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
        checks++;
        if (busy !== 1'b1 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_t1 got busy=%b rsp0_valid=%b exp 1 0", busy, rsp0_valid);
        end
        tick();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd12 || rsp1_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL add_t2 got v0=%b d0=%0d v1=%b busy=%b exp 1 12 0 1",
                     rsp0_valid, rsp0_data, rsp1_valid, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_t3 got busy=%b rsp0_valid=%b exp 0 0", busy, rsp0_valid);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive_req(0, 1'b1, 32'd10, 32'd3, C_SUB);
        drive_req(1, 1'b1, 32'd6, 32'd7, C_MUL);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL arb_first got r0=%b r1=%b exp 1 0", req0_ready, req1_ready);
        end
        tick();
        drive_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
        checks++;
        if (req1_ready !== 1'b0 || owner !== 1'b0) begin
            errors++;
            $display("FAIL arb_exec got r1=%b owner=%b exp 0 0", req1_ready, owner);
        end
        tick();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd7) begin
            errors++;
            $display("FAIL arb_sub got v=%b d=%0d exp 1 7", rsp0_valid, rsp0_data);
        end
        tick();
        checks++;
        if (req1_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arb_second_accept got r1=%b busy=%b exp 1 0", req1_ready, busy);
        end
        tick();
        drive_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (rsp1_valid !== 1'b0 || owner !== 1'b1) begin
                errors++;
                $display("FAIL arb_mul_wait[%0d] got v1=%b owner=%b exp 0 1", i, rsp1_valid, owner);
            end
            tick();
        end
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_data !== 32'd42 || rsp0_valid !== 1'b0 || owner !== 1'b1) begin
            errors++;
            $display("FAIL arb_mul got v1=%b d1=%0d v0=%b owner=%b exp 1 42 0 1",
                     rsp1_valid, rsp1_data, rsp0_valid, owner);
        end
        tick();
        checks++;
        if (owner !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arb_owner_hold got owner=%b busy=%b exp 1 0", owner, busy);
        end
    endtask

    task automatic test_backpressure();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drive_req(0, 1'b1, 32'd100, 32'd23, C_ADD);
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept got r0=%b exp 1", req0_ready);
        end
        tick();
        drive_req(0, 1'b1, 32'd999, 32'd555, C_MUL);
        drive_req(1, 1'b1, 32'd1, 32'd1, C_ADD);
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd123 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b d=%0d r0=%b r1=%b exp 1 123 0 0",
                         i, rsp0_valid, rsp0_data, req0_ready, req1_ready);
            end
            tick();
        end
        drive_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
        rsp1_ready = 1'b1;
        #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_wrong_ready got v0=%b v1=%b exp 1 0", rsp0_valid, rsp1_valid);
        end
        rsp0_ready = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_retire got busy=%b v0=%b exp 0 0", busy, rsp0_valid);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] va[4];
        logic [31:0] vb[4];
        logic [2:0]  vc[4];
        logic [31:0] ve[4];
        int          vl[4];
        logic [31:0] got;
        int          lat;
        va = '{32'hFFFF_FFFF, 32'd0, 32'h0001_0000, 32'h1234_5678};
        vb = '{32'd1, 32'd1, 32'h0001_0000, 32'h9ABC_DEF0};
        vc = '{C_ADD, C_SUB, C_MUL, C_BAD};
        ve = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
        vl = '{2, 2, 1 + MUL_LAT, 2};
        for (int i = 0; i < 4; i++) begin
            run_op(i % 2, va[i], vb[i], vc[i], got, lat);
            checks++;
            if (got !== ve[i] || lat != vl[i]) begin
                errors++;
                $display("FAIL wrap[%0d] got data=%h lat=%0d exp data=%h lat=%0d", i, got, lat, ve[i], vl[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive_req(0, 1'b1, 32'd3, 32'd4, C_MUL);
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_accept got r0=%b exp 1", req0_ready);
        end
        tick();
        drive_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
        tick();
        rst = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_exec got busy=%b exp 1", busy);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || owner !== 1'b0) begin
            errors++;
            $display("FAIL rmid_after got busy=%b owner=%b exp 0 0", busy, owner);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rmid_no_rsp got %0d valid cycles exp 0", seen);
        end
        drive_req(0, 1'b1, 32'd1, 32'd1, C_ADD);
        drive_req(1, 1'b1, 32'd1, 32'd1, C_ADD);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_grant got r0=%b r1=%b exp 1 0", req0_ready, req1_ready);
        end
        drive_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
    endtask

    task automatic test_fairness();
        logic [31:0] a0[3];
        logic [31:0] b0[3];
        logic [2:0]  c0[3];
        logic [31:0] a1[3];
        logic [31:0] b1[3];
        logic [2:0]  c1[3];
        int          order[$];
        int          exp_order[6];
        int          i0;
        int          i1;
        int          n0;
        int          n1;
        int          cyc;
        logic [31:0] e;
        a0 = '{32'd1, 32'd50, 32'h0000_F0F0};
        b0 = '{32'd2, 32'd8, 32'h0000_FF00};
        c0 = '{C_ADD, C_SUB, C_AND};
        a1 = '{32'h0F, 32'd9, 32'hFFFF_FFFF};
        b1 = '{32'hF0, 32'd9, 32'd2};
        c1 = '{C_OR, C_MUL, C_MUL};
        exp0_q = '{32'd3, 32'd42, 32'h0000_F000};
        exp1_q = '{32'hFF, 32'd81, 32'hFFFF_FFFE};
        exp_order = '{0, 1, 0, 1, 0, 1};
        do_reset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        i0 = 0; i1 = 0; n0 = 0; n1 = 0; cyc = 0;
        while ((n0 < 3 || n1 < 3) && cyc < 200) begin
            if (i0 < 3) drive_req(0, 1'b1, a0[i0], b0[i0], c0[i0]);
            else        drive_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
            if (i1 < 3) drive_req(1, 1'b1, a1[i1], b1[i1], c1[i1]);
            else        drive_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
            #1;
            if (req0_valid && req0_ready) begin order.push_back(0); i0++; end
            if (req1_valid && req1_ready) begin order.push_back(1); i1++; end
            if (rsp0_valid === 1'b1) begin
                e = (exp0_q.size() > 0) ? exp0_q.pop_front() : 32'hDEAD_BEEF;
                n0++;
                checks++;
                if (rsp0_data !== e) begin
                    errors++;
                    $display("FAIL fair_rsp0[%0d] got=%h exp=%h", n0, rsp0_data, e);
                end
            end
            if (rsp1_valid === 1'b1) begin
                e = (exp1_q.size() > 0) ? exp1_q.pop_front() : 32'hDEAD_BEEF;
                n1++;
                checks++;
                if (rsp1_data !== e) begin
                    errors++;
                    $display("FAIL fair_rsp1[%0d] got=%h exp=%h", n1, rsp1_data, e);
                end
            end
            tick();
            cyc++;
        end
        drive_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
        checks++;
        if (n0 != 3 || n1 != 3 || order.size() != 6) begin
            errors++;
            $display("FAIL fair_counts got n0=%0d n1=%0d grants=%0d exp 3 3 6", n0, n1, order.size());
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (k >= order.size() || order[k] != exp_order[k]) begin
                errors++;
                $display("FAIL fair_order[%0d] got=%0d exp=%0d", k,
                         (k < order.size()) ? order[k] : -1, exp_order[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_arbitration();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_fairness();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
